tape_ram_arbiter: RTL and testbench

TAPE_RAM_ARBITER -- requirements
Module: tape_ram_arbiter

---
 rtl/tape_ram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_tape_ram_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tape_ram_arbiter.sv
// tape_ram_arbiter: shares one DDR3 byte port between the ROM loader (writes)
// and the tape player (reads). Loader writes win over reads, tape reads wait
// while a download is active, and a watchdog aborts any command that never
// completes and raises a sticky error flag.
module tape_ram_arbiter #(
    parameter int TIMEOUT = 4095
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ld_active,
    input  logic        ld_wr,
    input  logic [24:0] ld_addr,
    input  logic [7:0]  ld_din,
    output logic        ld_wait,
    input  logic        tp_rd,
    input  logic [24:0] tp_addr,
    output logic [7:0]  tp_data,
    output logic        tp_valid,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready,
    output logic        err
);

    localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic              start_ok_q, start_ok_d;
    logic              ld_wait_q, ld_wait_d;
    logic              tp_valid_q, tp_valid_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_rd_q, mem_rd_d;
    logic              err_q, err_d;
    logic [24:0]       mem_addr_q, mem_addr_d;
    logic [7:0]        mem_din_q, mem_din_d;
    logic [7:0]        tp_data_q, tp_data_d;
    logic              pend_q, pend_d;
    logic [24:0]       pend_addr_q, pend_addr_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              seen_low_q, seen_low_d;
    logic [WD_W-1:0]   wd_inc;

    // Next-state logic: arbitration in IDLE, command issue, completion/abort in WAIT.
    always_comb begin
        state_d     = state_q;
        start_ok_d  = 1'b1;
        ld_wait_d   = ld_wait_q;
        tp_valid_d  = 1'b0;
        mem_we_d    = 1'b0;
        mem_rd_d    = 1'b0;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        tp_data_d   = tp_data_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        wd_d        = wd_q;
        seen_low_d  = seen_low_q;
        wd_inc      = wd_q + WD_W'(1);

        case (state_q)
            IDLE: begin
                // start_ok_q holds off arbitration for the first edge after reset release
                if (start_ok_q) begin
                    if (ld_wr) begin
                        mem_addr_d = ld_addr;
                        mem_din_d  = ld_din;
                        ld_wait_d  = 1'b1;
                        mem_we_d   = 1'b1;
                        state_d    = WR_ISSUE;
                    end else if (pend_q && !ld_active) begin
                        pend_d     = 1'b0;
                        mem_addr_d = pend_addr_q;
                        mem_rd_d   = 1'b1;
                        state_d    = RD_ISSUE;
                    end
                end
            end
            WR_ISSUE: begin
                wd_d       = '0;
                seen_low_d = 1'b0;
                state_d    = WR_WAIT;
            end
            RD_ISSUE: begin
                wd_d       = '0;
                seen_low_d = 1'b0;
                state_d    = RD_WAIT;
            end
            WR_WAIT, RD_WAIT: begin
                // A command is done only once ready has been seen low and then high again
                if (seen_low_q && mem_ready) begin
                    state_d = IDLE;
                    if (state_q == WR_WAIT) begin
                        ld_wait_d = 1'b0;
                    end else begin
                        tp_data_d  = mem_dout;
                        tp_valid_d = 1'b1;
                    end
                end else if (wd_inc == WD_LIMIT) begin
                    wd_d      = wd_inc;
                    err_d     = 1'b1;
                    ld_wait_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_inc;
                    if (!mem_ready) begin
                        seen_low_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A fresh tape request always lands in the slot, even on the cycle IDLE consumes it
        if (tp_rd) begin
            pend_d      = 1'b1;
            pend_addr_d = tp_addr;
        end
    end

    // State and output registers; reset abandons any command in flight.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            start_ok_q  <= 1'b0;
            ld_wait_q   <= 1'b0;
            tp_valid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            tp_data_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            wd_q        <= '0;
            seen_low_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_ok_q  <= start_ok_d;
            ld_wait_q   <= ld_wait_d;
            tp_valid_q  <= tp_valid_d;
            mem_we_q    <= mem_we_d;
            mem_rd_q    <= mem_rd_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            tp_data_q   <= tp_data_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            wd_q        <= wd_d;
            seen_low_q  <= seen_low_d;
        end
    end

    assign ld_wait  = ld_wait_q;
    assign tp_valid = tp_valid_q;
    assign mem_we   = mem_we_q;
    assign mem_rd   = mem_rd_q;
    assign err      = err_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign tp_data  = tp_data_q;

endmodule

// File: tb/tb_tape_ram_arbiter.sv
// tb_tape_ram_arbiter: randomized loader/tape traffic against a behavioural
// DDR3 byte-port model; expected read data comes from a separate address->byte
// map updated from the stimulus side, command order from the arbitration rules.
module tb_tape_ram_arbiter;

    localparam int TO = 15;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_active = 1'b0;
    logic        ld_wr = 1'b0;
    logic [24:0] ld_addr = '0;
    logic [7:0]  ld_din = '0;
    logic        ld_wait;
    logic        tp_rd = 1'b0;
    logic [24:0] tp_addr = '0;
    logic [7:0]  tp_data;
    logic        tp_valid;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        mem_rd;
    logic [7:0]  mem_dout = '0;
    logic        mem_ready = 1'b1;
    logic        err;

    tape_ram_arbiter #(.TIMEOUT(TO)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ld_active (ld_active),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_din    (ld_din),
        .ld_wait   (ld_wait),
        .tp_rd     (tp_rd),
        .tp_addr   (tp_addr),
        .tp_data   (tp_data),
        .tp_valid  (tp_valid),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .mem_dout  (mem_dout),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    // DDR3 byte-port model: a command drops ready, which returns after a latency
    int          fixed_lat = 0;
    bit          stall = 1'b0;
    bit          mem_inited = 1'b0;
    logic [7:0]  ddr [0:255];
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    bit          rd_pend = 1'b0;
    logic [24:0] rd_addr = '0;

    always @(posedge clk_sys) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) ddr[i] <= 8'(i) ^ 8'h1F;
            mem_inited <= 1'b1;
        end
        if (mem_we || mem_rd) begin
            if (mem_we) ddr[mem_addr[7:0]] <= mem_din;
            mem_busy  <= 1'b1;
            mem_ready <= 1'b0;
            mem_cnt   <= ((fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 8))) - 1;
            rd_pend   <= mem_rd;
            rd_addr   <= mem_addr;
        end else if (mem_busy && !stall) begin
            if (mem_cnt == 0) begin
                mem_busy  <= 1'b0;
                mem_ready <= 1'b1;
                if (rd_pend) mem_dout <= ddr[rd_addr[7:0]];
            end else begin
                mem_cnt <= mem_cnt - 1;
            end
        end
    end

    // Observed command and tape-valid history
    typedef struct packed {
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  din;
    } cmd_t;
    cmd_t       cmd_q[$];
    logic [7:0] tv_q[$];

    always @(negedge clk_sys) begin
        if (mem_we) cmd_q.push_back({1'b1, mem_addr, mem_din});
        if (mem_rd) cmd_q.push_back({1'b0, mem_addr, 8'h00});
        if (tp_valid) tv_q.push_back(tp_data);
    end

    // Reference contents: what the loader has written, else the power-up pattern
    logic [7:0]  exp_mem [logic [24:0]];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [7:0] exp_rd(input logic [24:0] a);
        if (exp_mem.exists(a)) return exp_mem[a];
        return a[7:0] ^ 8'h1F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (tp_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_cmd(input string tag, input int idx, input logic wr,
                             input logic [24:0] a, input logic [7:0] d);
        if (idx < cmd_q.size()) begin
            chk({tag, "_kind"}, 32'(cmd_q[idx].wr), 32'(wr));
            chk({tag, "_addr"}, 32'(cmd_q[idx].addr), 32'(a));
            if (wr) chk({tag, "_din"}, 32'(cmd_q[idx].din), 32'(d));
        end else begin
            chk({tag, "_present"}, 32'(cmd_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic do_write(input logic [24:0] a, input logic [7:0] d);
        int base, rise_at, done_at;
        bit low_seen;
        base = cmd_q.size();
        rise_at = -1;
        done_at = -1;
        low_seen = 1'b0;
        ld_wr = 1'b1; ld_addr = a; ld_din = d;
        cyc();
        ld_wr = 1'b0;
        chk("wr_wait_set", 32'(ld_wait), 32'd1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (!ld_wait) begin
                done_at = i;
                break;
            end
            if (!mem_ready) low_seen = 1'b1;
            else if (low_seen && rise_at < 0) rise_at = i;
        end
        chk("wr_wait_drop_after_ready", 32'(done_at - rise_at), 32'd1);
        exp_mem[a] = d;
        cyc();
        chk("wr_cmd_count", 32'(cmd_q.size() - base), 32'd1);
        check_cmd("wr_cmd", base, 1'b1, a, d);
    endtask

    task automatic finish_read(input string tag, input logic [24:0] a, input int base);
        bit got;
        wait_valid(got);
        chk({tag, "_valid"}, 32'(got), 32'd1);
        chk({tag, "_data"}, 32'(tp_data), 32'(exp_rd(a)));
        @(negedge clk_sys);
        chk({tag, "_pulse1"}, 32'(tp_valid), 32'd0);
        chk({tag, "_hold"}, 32'(tp_data), 32'(exp_rd(a)));
        cyc();
        chk({tag, "_cmd_count"}, 32'(cmd_q.size() - base), 32'd1);
        check_cmd({tag, "_cmd"}, base, 1'b0, a, 8'h00);
    endtask

    task automatic do_read(input logic [24:0] a);
        int base;
        base = cmd_q.size();
        tp_rd = 1'b1; tp_addr = a;
        cyc();
        tp_rd = 1'b0;
        finish_read("rd", a, base);
    endtask

    task automatic do_hold_read(input logic [24:0] a, input int n);
        int base;
        base = cmd_q.size();
        ld_active = 1'b1;
        tp_rd = 1'b1; tp_addr = a;
        cyc();
        tp_rd = 1'b0;
        repeat (n) @(negedge clk_sys);
        chk("hold_no_rd", 32'(cmd_q.size() - base), 32'd0);
        cyc();
        ld_active = 1'b0;
        finish_read("hold_rd", a, base);
    endtask

    task automatic do_collide(input logic [24:0] wa, input logic [7:0] wd, input logic [24:0] ra);
        int base;
        bit got;
        base = cmd_q.size();
        tp_rd = 1'b1; tp_addr = ra;
        cyc();
        tp_rd = 1'b0;
        ld_wr = 1'b1; ld_addr = wa; ld_din = wd;
        cyc();
        ld_wr = 1'b0;
        exp_mem[wa] = wd;
        wait_valid(got);
        chk("col_valid", 32'(got), 32'd1);
        chk("col_data", 32'(tp_data), 32'(exp_rd(ra)));
        chk("col_ld_wait", 32'(ld_wait), 32'd0);
        cyc();
        chk("col_cmd_count", 32'(cmd_q.size() - base), 32'd2);
        check_cmd("col_first", base, 1'b1, wa, wd);
        check_cmd("col_second", base + 1, 1'b0, ra, 8'h00);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ld_wait"}, 32'(ld_wait), 32'd0);
        chk({tag, "_tp_valid"}, 32'(tp_valid), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_din"}, 32'(mem_din), 32'd0);
        chk({tag, "_tp_data"}, 32'(tp_data), 32'd0);
    endtask

    // Overall time bound
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time bound exceeded");
    end

    logic [24:0] pool [8];

    initial begin
        int          op, vb, cnt, base;
        bit          seen;
        logic [24:0] wa, ra;
        logic [7:0]  wdat;

        for (int i = 0; i < 8; i++) pool[i] = {17'($urandom), 8'h40 + 8'(i * 17)};

        // Power-on reset
        repeat (3) cyc();
        check_reset_outputs("por");
        reset_n = 1'b1;
        repeat (3) cyc();

        // Single write, memory busy for 5 cycles
        fixed_lat = 5;
        do_write(25'h000010, 8'hA5);

        // Single read, data back after 8 cycles
        fixed_lat = 8;
        do_read(25'h000123);
        chk("rd_0x123_value", 32'(tp_data), 32'h3C);
        fixed_lat = 0;

        // Write and pending read meet in IDLE; read of the same byte sees new data
        do_collide(pool[0], 8'hC7, pool[0]);

        // Read held off by an active download
        do_hold_read(pool[1], 100);

        // Watchdog abort with memory stuck busy
        stall = 1'b1;
        vb = tv_q.size();
        tp_rd = 1'b1; tp_addr = pool[2];
        cyc();
        tp_rd = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (mem_rd) begin
                seen = 1'b1;
                break;
            end
        end
        chk("to_rd_issued", 32'(seen), 32'd1);
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys);
            if (err) break;
            cnt++;
        end
        chk("to_wait_cycles", 32'(cnt), 32'(TO));
        chk("to_err", 32'(err), 32'd1);
        chk("to_ld_wait", 32'(ld_wait), 32'd0);
        cyc();
        stall = 1'b0;
        for (int i = 0; i < 30 && !mem_ready; i++) cyc();
        repeat (2) cyc();
        chk("to_no_valid", 32'(tv_q.size() - vb), 32'd0);
        do_read(pool[3]);
        chk("to_err_sticky", 32'(err), 32'd1);

        // Reset in the middle of a read
        fixed_lat = 10;
        vb = tv_q.size();
        tp_rd = 1'b1; tp_addr = pool[4];
        cyc();
        tp_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (mem_rd) break;
        end
        repeat (4) @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        for (int i = 0; i < 40 && !mem_ready; i++) cyc();
        repeat (2) cyc();
        fixed_lat = 0;
        // Loader strobe already present when reset releases: first command on the second edge
        base = cmd_q.size();
        ld_wr = 1'b1; ld_addr = pool[5]; ld_din = 8'h6E;
        reset_n = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rel_edge1_we", 32'(mem_we), 32'd0);
        chk("rel_edge1_ld_wait", 32'(ld_wait), 32'd0);
        @(posedge clk_sys);
        #1;
        ld_wr = 1'b0;
        @(negedge clk_sys);
        chk("rel_edge2_we", 32'(mem_we), 32'd1);
        chk("rel_edge2_addr", 32'(mem_addr), 32'(pool[5]));
        for (int i = 0; i < 40 && ld_wait; i++) @(negedge clk_sys);
        chk("rel_wr_done", 32'(ld_wait), 32'd0);
        exp_mem[pool[5]] = 8'h6E;
        cyc();
        chk("rel_cmd_count", 32'(cmd_q.size() - base), 32'd1);
        chk("rst_no_valid", 32'(tv_q.size() - vb), 32'd0);
        do_read(pool[4]);
        do_read(pool[5]);

        // Randomized mix of loader writes, tape reads, collisions and held reads
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 3));
            wa = pool[$urandom_range(0, 7)];
            ra = pool[$urandom_range(0, 7)];
            wdat = 8'($urandom);
            case (op)
                0: do_write(wa, wdat);
                1: do_read(ra);
                2: do_collide(wa, wdat, ra);
                default: do_hold_read(ra, int'($urandom_range(1, 12)));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
